// File: rtl/pow2_gen.sv
// Sequential power-of-two source: single exponent or full sweep, delivered
// over a valid/ready handshake. result is MSB-first (index 0 is the MSB).
module pow2_gen #(
  parameter int WIDTH = 8,
  parameter int EW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            sweep,
  input  logic [EW-1:0]   exp,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:WIDTH-1] result,
  output logic            last,
  output logic            err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [EW-1:0] EXP_LIMIT = EW'(WIDTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [EW-1:0]    cnt;
  logic [IW-1:0]    sweep_idx;
  logic             mode_sweep;
  logic             err_q;

  logic             in_done;
  logic             sweep_last;
  logic             accept;
  logic             final_accept;

  assign in_done      = (state == DONE);
  assign sweep_last   = (sweep_idx == LAST_IDX);
  assign accept       = in_done && out_ready;
  assign final_accept = accept && (!mode_sweep || sweep_last);

  // The first shift happens on the start edge itself (acc loads 2, cnt loads
  // exp-1), so 2^exp is valid after edge max(exp,1) with exactly exp shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      sweep_idx  <= '0;
      mode_sweep <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sweep_idx <= '0;
            if (sweep) begin
              mode_sweep <= 1'b1;
              acc        <= WIDTH'(1);
              cnt        <= '0;
              err_q      <= 1'b0;
              state      <= DONE;
            end else if (exp >= EXP_LIMIT) begin
              mode_sweep <= 1'b0;
              acc        <= '0;
              cnt        <= '0;
              err_q      <= 1'b1;
              state      <= DONE;
            end else if (exp == '0) begin
              mode_sweep <= 1'b0;
              acc        <= WIDTH'(1);
              cnt        <= '0;
              err_q      <= 1'b0;
              state      <= DONE;
            end else begin
              mode_sweep <= 1'b0;
              acc        <= WIDTH'(2);
              cnt        <= exp - EW'(1);
              err_q      <= 1'b0;
              state      <= (exp == EW'(1)) ? DONE : SHIFT;
            end
          end
        end

        SHIFT: begin
          acc <= acc << 1;
          cnt <= cnt - EW'(1);
          if (cnt == EW'(1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          if (final_accept) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sweep_idx  <= '0;
            mode_sweep <= 1'b0;
            err_q      <= 1'b0;
          end else if (accept) begin
            acc       <= acc << 1;
            sweep_idx <= sweep_idx + IW'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = in_done;
  assign result    = in_done ? acc : '0;
  assign last      = in_done && (!mode_sweep || sweep_last);
  assign err       = in_done && err_q;

endmodule

// File: tb/tb_pow2_gen.sv
// Bench for pow2_gen: directed test-plan steps plus randomized requests,
// checked against a power-of-two reference computed from the exponent.
module tb_pow2_gen;

  localparam int W   = 8;
  localparam int EWP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sweep = 1'b0;
  logic [EWP-1:0] exp_v = '0;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          out_valid;
  logic [0:W-1]  result;
  logic          last;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pow2_gen #(.WIDTH(W), .EW(EWP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sweep     (sweep),
    .exp       (exp_v),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .last      (last),
    .err       (err)
  );

  function automatic logic [W-1:0] pow2_ref(input int e);
    logic [W-1:0] v;
    v = '0;
    if (e >= 0 && e < W) v[e] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_res"},   32'(result),    32'd0);
    chk({tag, "_last"},  32'(last),      32'd0);
    chk({tag, "_err"},   32'(err),       32'd0);
  endtask

  // noise: 0 quiet, 1 random start/exp/sweep while busy, 2 start with exp=1 while busy
  task automatic drive_noise(input int noise);
    if (noise == 1) begin
      start = 1'($urandom);
      exp_v = EWP'($urandom);
      sweep = 1'($urandom);
    end else if (noise == 2) begin
      start = 1'b1;
      exp_v = EWP'(1);
      sweep = 1'b0;
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic run_single(input int e, input bit rnd_ready, input int noise);
    logic [W-1:0] want;
    int lat, n;
    bit r, is_err;
    is_err = (e >= W);
    want   = pow2_ref(e);
    lat    = (is_err || e < 1) ? 1 : e;
    @(negedge clk);
    start = 1'b1; sweep = 1'b0; exp_v = EWP'(e); out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      drive_noise(noise);
    end while (!out_valid && n < 64);
    chk("single_latency", 32'(n), 32'(lat));
    chk("single_result",  32'(result), 32'(want));
    chk("single_err",     32'(err), 32'(is_err));
    chk("single_last",    32'(last), 32'd1);
    if (!is_err) chk("single_onehot", 32'($countones(result)), 32'd1);
    n = 0;
    do begin
      r = rnd_ready ? 1'($urandom) : 1'b1;
      out_ready = r;
      drive_noise(noise);
      @(negedge clk);
      n++;
      if (!r) begin
        chk("single_hold_valid",  32'(out_valid), 32'd1);
        chk("single_hold_result", 32'(result), 32'(want));
      end
    end while (!r && n < 64);
    chk("single_accept_bound", 32'(r), 32'd1);
    start = 1'b0; sweep = 1'b0; out_ready = 1'b0;
    chk_idle("single_post");
    @(negedge clk);
    chk_idle("single_post2");
  endtask

  // mode: 0 ready held high, 1 ready toggling from 0, 2 random ready
  task automatic run_sweep(input int mode);
    int idx, vcyc, accepts, n;
    bit r, tog;
    @(negedge clk);
    start = 1'b1; sweep = 1'b1; exp_v = EWP'($urandom); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; sweep = 1'b0;
    chk("sweep_first_latency", 32'(out_valid), 32'd1);
    idx = 0; vcyc = 0; accepts = 0; n = 0; tog = 1'b0;
    while (idx < W && n < 200) begin
      chk("sweep_valid",  32'(out_valid), 32'd1);
      chk("sweep_result", 32'(result), 32'(pow2_ref(idx)));
      chk("sweep_last",   32'(last), 32'(idx == W - 1));
      chk("sweep_err",    32'(err), 32'd0);
      if (!out_valid) break;
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = !tog; end
        default: r = 1'($urandom);
      endcase
      out_ready = r;
      if (mode != 0) drive_noise(1);
      vcyc++;
      @(negedge clk);
      start = 1'b0; sweep = 1'b0;
      n++;
      if (r) begin
        idx++;
        accepts++;
      end
    end
    out_ready = 1'b0;
    chk("sweep_accepts", 32'(accepts), 32'(W));
    if (mode == 0) chk("sweep_valid_cycles", 32'(vcyc), 32'(W));
    if (mode == 1) chk("sweep_valid_cycles", 32'(vcyc), 32'(2 * W));
    chk_idle("sweep_post");
  endtask

  initial begin
    #1;
    chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_single(0, 1'b0, 0);
    run_single(2, 1'b0, 0);
    run_single(7, 1'b0, 0);
    run_single(8, 1'b0, 0);
    run_single(15, 1'b0, 0);
    run_single(4, 1'b1, 0);

    run_sweep(0);
    run_sweep(1);

    run_single(6, 1'b0, 2);
    run_single(6, 1'b1, 2);

    @(negedge clk);
    start = 1'b1; sweep = 1'b0; exp_v = EWP'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_single(3, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run_single(int'($urandom_range(0, 15)), 1'b1, 1);
    end
    run_sweep(2);
    run_sweep(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
